// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg -- shared definitions for the RV32I fetch front end.
//
// Contents:
//   PC_SRC_*          pc_src encodings driven by the decode stage
//   *_VECTOR_DEF      default reset and trap vectors
//   pc_state_e        pc_gen control states
//   redir_pri_e       ranking of redirect sources; a larger value wins
//   misaligned()      target alignment test for 32-bit instructions
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_REL  = 2'b01;
    localparam logic [1:0] PC_SRC_JALR = 2'b10;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

    // Numeric order matters: pending redirects are replaced only by a
    // strictly larger value.
    typedef enum logic [1:0] {
        PRI_NONE = 2'd0,
        PRI_BR   = 2'd1,
        PRI_MRET = 2'd2,
        PRI_TRAP = 2'd3
    } redir_pri_e;

    // Without the C extension every instruction address is word aligned.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc -- combinational next-PC selection for pc_gen.
//
// Ports:
//   pc_i          current fetch address
//   pc_src_i      00 seq, 01 PC+imm, 10 (rs1+imm)&~1, 11 treated as seq
//   trap_i        exception/interrupt request (highest priority)
//   mret_i        return from trap, target mepc_i
//   imm_i         sign-extended immediate
//   rs1_i         JALR base
//   mepc_i        mret return address
//   target_o      next PC; already replaced by TRAP_VECTOR when misaligned
//   misaligned_o  redirect target was not word aligned
//   capture_o     this target must save the current PC into mepc
//   pri_o         rank of the selected source (PRI_NONE for sequential)
// ---------------------------------------------------------------------------
module pc_target_calc
    import rv_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEF),
    parameter int unsigned      INC         = 4
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      pc_src_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o,
    output logic            capture_o,
    output redir_pri_e      pri_o
);

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] jalr_sum;
    logic            check_align;

    assign jalr_sum = rs1_i + imm_i;

    always_comb begin
        raw         = pc_i + XLEN'(INC);
        pri_o       = PRI_NONE;
        check_align = 1'b0;

        if (trap_i) begin
            raw   = TRAP_VECTOR;
            pri_o = PRI_TRAP;
        end else if (mret_i) begin
            raw         = mepc_i;
            pri_o       = PRI_MRET;
            check_align = 1'b1;
        end else if (pc_src_i == PC_SRC_REL) begin
            raw         = pc_i + imm_i;
            pri_o       = PRI_BR;
            check_align = 1'b1;
        end else if (pc_src_i == PC_SRC_JALR) begin
            raw         = {jalr_sum[XLEN-1:1], 1'b0};
            pri_o       = PRI_BR;
            check_align = 1'b1;
        end

        // Sequential and trap targets are aligned by construction, so only
        // true redirects are tested.
        misaligned_o = check_align & misaligned(raw[1:0]);
        target_o     = misaligned_o ? TRAP_VECTOR : raw;
        capture_o    = trap_i | misaligned_o;
    end

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program-counter generator for the RV32I fetch stage.
//
// Ports:
//   clk             rising-edge clock
//   areset          asynchronous active-low reset
//   load            pipeline advance enable (0 holds the PC)
//   pc_src          next-PC source select from decode
//   imm_ext         sign-extended immediate
//   rs1             JALR base register value
//   trap            exception/interrupt request
//   mret            return from trap
//   mepc_in         mret return address
//   fetch_ready     instruction memory accepts pc_out this cycle
//   pc_out          current fetch address
//   pc_plus         pc_out + INC (link value), combinational
//   fetch_valid     pc_out is a valid fetch request
//   misaligned_exc  one-cycle pulse with the PC update of a misaligned redirect
//   mepc_out        PC saved on trap or misaligned redirect
//
// A fetch is accepted on fetch_valid & fetch_ready & load and the PC moves
// only then, so the address seen by memory is stable across a stall. A
// redirect seen without an accept is parked in a pending register (HOLD)
// and replayed on the next accept whatever the inputs are in that cycle.
// ---------------------------------------------------------------------------
module pc_gen
    import rv_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int unsigned      INC          = 4
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            load,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] rs1,
    input  logic            trap,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc_in,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic            misaligned_exc,
    output logic [XLEN-1:0] mepc_out
);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            fetch_valid_q;
    logic            mis_exc_q;
    logic [XLEN-1:0] mepc_q;

    // Pending redirect captured during a stall.
    logic [XLEN-1:0] pend_pc_q;
    logic            pend_mis_q;
    logic            pend_cap_q;
    redir_pri_e      pend_pri_q;

    logic [XLEN-1:0] tgt;
    logic            tgt_mis;
    logic            tgt_cap;
    redir_pri_e      tgt_pri;
    logic            accept_d;
    logic            redirect_d;

    pc_target_calc #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INC         (INC)
    ) u_target (
        .pc_i         (pc_q),
        .pc_src_i     (pc_src),
        .trap_i       (trap),
        .mret_i       (mret),
        .imm_i        (imm_ext),
        .rs1_i        (rs1),
        .mepc_i       (mepc_in),
        .target_o     (tgt),
        .misaligned_o (tgt_mis),
        .capture_o    (tgt_cap),
        .pri_o        (tgt_pri)
    );

    assign accept_d   = fetch_valid_q & fetch_ready & load;
    assign redirect_d = (tgt_pri != PRI_NONE);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            mis_exc_q     <= 1'b0;
            mepc_q        <= '0;
            pend_pc_q     <= '0;
            pend_mis_q    <= 1'b0;
            pend_cap_q    <= 1'b0;
            pend_pri_q    <= PRI_NONE;
        end else begin
            mis_exc_q <= 1'b0;  // pulse, re-armed only by an update below
            case (state_q)
                // One idle cycle after reset; PC stays at the reset vector.
                ST_BOOT: begin
                    state_q       <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                end

                ST_RUN: begin
                    if (accept_d) begin
                        pc_q      <= tgt;
                        mis_exc_q <= tgt_mis;
                        if (tgt_cap) mepc_q <= pc_q;
                    end else if (redirect_d) begin
                        pend_pc_q  <= tgt;
                        pend_mis_q <= tgt_mis;
                        pend_cap_q <= tgt_cap;
                        pend_pri_q <= tgt_pri;
                        state_q    <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (accept_d) begin
                        // The parked redirect wins over this cycle's inputs.
                        pc_q       <= pend_pc_q;
                        mis_exc_q  <= pend_mis_q;
                        if (pend_cap_q) mepc_q <= pc_q;
                        pend_pri_q <= PRI_NONE;
                        state_q    <= ST_RUN;
                    end else if (tgt_pri > pend_pri_q) begin
                        // pc_q is frozen in HOLD, so a recomputed target is
                        // still relative to the stalled fetch address.
                        pend_pc_q  <= tgt;
                        pend_mis_q <= tgt_mis;
                        pend_cap_q <= tgt_cap;
                        pend_pri_q <= tgt_pri;
                    end
                end

                default: begin
                    state_q       <= ST_BOOT;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out         = pc_q;
    assign pc_plus        = pc_q + XLEN'(INC);
    assign fetch_valid    = fetch_valid_q;
    assign misaligned_exc = mis_exc_q;
    assign mepc_out       = mepc_q;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed and randomized checks of pc_gen against a
// transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        areset;
    logic        load;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] rs1;
    logic        trap;
    logic        mret;
    logic [31:0] mepc_in;
    logic        fetch_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic        misaligned_exc;
    logic [31:0] mepc_out;

    int n_vec = 0;
    int n_err = 0;

    pc_gen dut (
        .clk            (clk),
        .areset         (areset),
        .load           (load),
        .pc_src         (pc_src),
        .imm_ext        (imm_ext),
        .rs1            (rs1),
        .trap           (trap),
        .mret           (mret),
        .mepc_in        (mepc_in),
        .fetch_ready    (fetch_ready),
        .pc_out         (pc_out),
        .pc_plus        (pc_plus),
        .fetch_valid    (fetch_valid),
        .misaligned_exc (misaligned_exc),
        .mepc_out       (mepc_out)
    );

    always #5 clk = ~clk;

    // Reference model: the architectural view of the fetch unit.
    logic [31:0] m_pc;
    logic [31:0] m_mepc;
    bit          m_started;    // false during the idle cycle after reset
    bit          m_exc;
    bit          p_have;       // a redirect is waiting for the next fetch
    logic [31:0] p_pc;
    bit          p_exc;
    bit          p_save;
    int          p_rank;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_mepc = 32'h0; m_started = 0; m_exc = 0; p_have = 0;
    endtask

    // Evaluate the request presented in the cycle that just ended.
    task automatic model_edge();
        int          rank;
        logic [31:0] dest;
        bit          bad;
        bit          save;
        bit          fetched;
        rank = 0; bad = 0; save = 0;
        if (trap)              begin rank = 3; dest = TV; save = 1; end
        else if (mret)         begin rank = 2; dest = mepc_in; end
        else if (pc_src == 1)  begin rank = 1; dest = m_pc + imm_ext; end
        else if (pc_src == 2)  begin rank = 1; dest = (rs1 + imm_ext) & 32'hFFFF_FFFE; end
        else                   dest = m_pc + 32'd4;
        if (rank == 1 || rank == 2) begin
            if (dest % 4 != 0) begin bad = 1; save = 1; dest = TV; end
        end
        fetched = m_started && fetch_ready && load;
        m_exc = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (fetched) begin
            if (p_have) begin dest = p_pc; bad = p_exc; save = p_save; end
            if (save) m_mepc = m_pc;
            m_pc   = dest;
            m_exc  = bad;
            p_have = 0;
        end else if (rank > 0 && (!p_have || rank > p_rank)) begin
            p_have = 1; p_pc = dest; p_exc = bad; p_save = save; p_rank = rank;
        end
    endtask

    task automatic check_all();
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus", pc_plus, m_pc + 32'd4);
        chk("fetch_valid", 32'(fetch_valid), 32'(m_started));
        chk("misaligned_exc", 32'(misaligned_exc), 32'(m_exc));
        chk("mepc_out", mepc_out, m_mepc);
    endtask

    task automatic step();
        @(posedge clk);
        if (areset) model_edge();
        else        model_reset();
        #1;
        check_all();
    endtask

    task automatic drive(input bit ld, input bit rdy, input logic [1:0] src,
                         input logic [31:0] im, input logic [31:0] r1,
                         input bit tr, input bit mr, input logic [31:0] me);
        load = ld; fetch_ready = rdy; pc_src = src; imm_ext = im;
        rs1 = r1; trap = tr; mret = mr; mepc_in = me;
    endtask

    task automatic idle();
        drive(1, 1, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0);
    endtask

    // Jump to an aligned address through mret.
    task automatic go_to(input logic [31:0] a);
        drive(1, 1, 2'b00, 32'h0, 32'h0, 0, 1, a);
        step();
        idle();
    endtask

    // Asynchronous reset between clock edges, held across one edge.
    task automatic pulse_reset();
        areset = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        areset = 1'b1;
    endtask

    initial begin
        areset = 1'b0;
        idle();
        model_reset();
        #12;
        check_all();
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_fv", 32'(fetch_valid), 32'h0);
        areset = 1'b1;

        // 1: boot cycle, then sequential fetch
        step();
        chk("boot_pc", pc_out, 32'h0);
        step(); chk("seq4", pc_out, 32'h4);
        step(); chk("seq8", pc_out, 32'h8);
        step(); chk("seqC", pc_out, 32'hC);

        // 2: PC-relative back branch, then JALR clears bit 0
        go_to(32'h20);
        drive(1, 1, 2'b01, 32'hFFFF_FFF0, 32'h0, 0, 0, 32'h0); step();
        chk("rel_back", pc_out, 32'h10);
        drive(1, 1, 2'b10, 32'h0, 32'h101, 0, 0, 32'h0); step();
        chk("jalr", pc_out, 32'h100);

        // 3: misaligned branch target
        idle(); go_to(32'h40);
        drive(1, 1, 2'b01, 32'h6, 32'h0, 0, 0, 32'h0); step();
        chk("mis_pc", pc_out, TV);
        chk("mis_exc", 32'(misaligned_exc), 32'h1);
        chk("mis_mepc", mepc_out, 32'h40);
        idle(); step();
        chk("mis_pulse_end", 32'(misaligned_exc), 32'h0);

        // 4: branch during a three-cycle stall
        go_to(32'h80);
        drive(1, 0, 2'b01, 32'h180, 32'h0, 0, 0, 32'h0); step();
        chk("stall1_pc", pc_out, 32'h80);
        drive(1, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0); step();
        chk("stall2_pc", pc_out, 32'h80);
        step();
        chk("stall3_pc", pc_out, 32'h80);
        chk("stall_fv", 32'(fetch_valid), 32'h1);
        idle(); step();
        chk("stall_release", pc_out, 32'h200);

        // 5: trap beats mret, then mret alone
        go_to(32'h30);
        drive(1, 1, 2'b00, 32'h0, 32'h0, 1, 1, 32'h44); step();
        chk("trap_pc", pc_out, TV);
        chk("trap_mepc", mepc_out, 32'h30);
        drive(1, 1, 2'b00, 32'h0, 32'h0, 0, 1, 32'h44); step();
        chk("mret_pc", pc_out, 32'h44);

        // wrap-around of the sequential increment
        idle(); go_to(32'hFFFF_FFFC);
        step();
        chk("wrap", pc_out, 32'h0);

        // 6: reset while a redirect is pending
        go_to(32'h80);
        drive(1, 0, 2'b01, 32'h100, 32'h0, 0, 0, 32'h0); step();
        idle();
        areset = 1'b0;
        #1;
        chk("async_pc", pc_out, 32'h0);
        chk("async_fv", 32'(fetch_valid), 32'h0);
        model_reset();
        step();
        areset = 1'b1;
        step();
        chk("reboot_pc", pc_out, 32'h0);
        step();
        chk("reboot_seq", pc_out, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] r;
            logic [31:0] im;
            logic [31:0] me;
            logic [1:0]  src;
            if ($urandom_range(0, 199) == 0) pulse_reset();
            r  = $urandom;
            im = {{20{r[11]}}, r[11:1], 1'b0};
            if ($urandom_range(0, 2) != 0) im[1] = 1'b0;
            me = $urandom & 32'hFFFF_FFFE;
            if ($urandom_range(0, 3) != 0) me[1] = 1'b0;
            src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), src, im,
                  $urandom, ($urandom_range(0, 24) == 0), ($urandom_range(0, 11) == 0), me);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the RV32I fetch stage. It is the successor to the single-mode PC register. It selects the next PC from five sources: sequential, PC-relative (branch/JAL), register-indirect (JALR), trap vector and trap return. Fetch requests go to instruction memory over a valid/ready handshake. A redirect that arrives during a memory stall is buffered and applied when the stall ends, so the fetch address stays stable. Misaligned targets are detected and raise an exception.

Parameters:
XLEN, 32, datapath/PC width
RESET_VECTOR, 0, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned target
INC, 4, sequential increment in bytes

Ports:
clk  in  1  rising-edge clock
areset  in  1  asynchronous active-low reset
load  in  1  pipeline advance enable (0 = hold PC)
pc_src  in  2  00 seq, 01 PC+imm, 10 (rs1+imm)&~1, 11 reserved (treated as seq)
imm_ext  in  XLEN  sign-extended immediate
rs1  in  XLEN  JALR base register value
trap  in  1  synchronous exception/interrupt request
mret  in  1  return from trap
mepc_in  in  XLEN  return address for mret
fetch_ready  in  1  instruction memory accepts pc_out this cycle
pc_out  out  XLEN  current fetch address
pc_plus  out  XLEN  pc_out+INC (link value), combinational
fetch_valid  out  1  pc_out is a valid fetch request
misaligned_exc  out  1  one-cycle pulse: redirect target[1:0]!=0
mepc_out  out  XLEN  PC captured on trap/misaligned event

Behaviour:
- Reset (areset=0, any time, including mid-stall):
  - pc_out=RESET_VECTOR, fetch_valid=0, misaligned_exc=0, mepc_out=0.
  - Pending redirect cleared; state=BOOT.
- FSM states: BOOT, RUN, HOLD.
  - BOOT: one cycle after reset release with fetch_valid=0, then RUN. The PC does not change in BOOT.
  - RUN: fetch_valid=1.
  - HOLD: fetch_valid=1; a redirect is buffered and the request is stalled (fetch_ready=0).
- Accept: accept = fetch_valid & fetch_ready & load. The PC updates only on accept.
  - Without accept, pc_out is held bit-exact, so fetch_valid stays stable.
- Next-PC priority, highest first: trap > mret > pc_src redirect > sequential.
  - trap: next=TRAP_VECTOR; mepc_out<=pc_out.
  - mret: next=mepc_in.
  - pc_src=01: next=pc_out+imm_ext.
  - pc_src=10: next=(rs1+imm_ext) with bit0 cleared.
  - Otherwise: next=pc_out+INC.
- Arithmetic: all sums are modulo 2^XLEN, so 32'hFFFF_FFFC+4 wraps to 0.
- Misaligned target: a redirect from pc_src 01/10 or mret whose target[1]=1 is not taken.
  - next=TRAP_VECTOR, mepc_out<=pc_out.
  - misaligned_exc pulses high for exactly one cycle, aligned with the PC update.
- Stall buffering: if trap, mret or a non-seq pc_src is asserted while fetch_valid=1 and fetch_ready=0:
  - The computed target and its misaligned flag are latched into a pending register; state=HOLD.
  - On the next accept, the pending target is loaded regardless of the inputs in that cycle, then state=RUN.
  - A later redirect during HOLD replaces the pending one only if it has higher priority. A trap always wins.
- load=0 with fetch_ready=1: no accept; redirects are still buffered (state→HOLD).
- Latency: the PC update is visible on pc_out one cycle after the accepting edge.

Decomposition:
- Shared package rv_pkg: PC_SRC_SEQ/PC_SRC_REL/PC_SRC_JALR encodings, the pc_gen state enum, RESET_VECTOR and TRAP_VECTOR defaults.
- Sub-module pc_target_calc: purely combinational. Computes the target and the misaligned flag from pc_src, trap, mret and the operands. pc_gen holds only the registers and the FSM.

Test Plan:
1. Reset release, fetch_ready=1, load=1, pc_src=00:
   - pc_out=0 with fetch_valid=0 for one cycle.
   - Then 0→4→8→C on consecutive cycles.
2. pc_out=0x20, pc_src=01, imm_ext=0xFFFFFFF0, accept:
   - pc_out=0x10.
   - Next cycle with pc_src=10, rs1=0x101, imm_ext=0 → pc_out=0x100.
3. pc_out=0x40, pc_src=01, imm_ext=0x6, accept:
   - pc_out=TRAP_VECTOR, misaligned_exc high for 1 cycle, mepc_out=0x40.
4. pc_out=0x80, fetch_ready=0 for 3 cycles, branch to 0x200 asserted in stall cycle 1 only:
   - pc_out stays 0x80 and fetch_valid stays 1 throughout.
   - On the fetch_ready=1 cycle, pc_out becomes 0x200.
5. trap and mret (mepc_in=0x44) asserted together at pc_out=0x30:
   - pc_out=0x100, mepc_out=0x30.
   - A later mret alone gives pc_out=0x44.
6. areset pulsed low mid-HOLD with a pending redirect:
   - pc_out returns to 0 immediately and the pending redirect is discarded.
   - After BOOT, the sequence restarts 0→4.
